// File: rtl/wb_pkg.sv
// Shared Wibone bus defaults, arbiter state encoding and UART register map.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] UART_CTRL  = 8'd3;
    localparam logic [7:0] UART_BAUD  = 8'd4;
    localparam logic [7:0] UART_STAT  = 8'd5;
    localparam logic [7:0] UART_TXBUF = 8'd7;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational two-requester round-robin picker; on a tie the requester
// that is not last_i wins.
module wb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = '0;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
            default: pick_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_uart_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of the UART slave.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_uart_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W         = WB_ADDR_W,
    parameter int unsigned DATA_W         = WB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                ext_rst_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_lock_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_rty_o,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_lock_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_rty_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_lock_o,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    output logic [1:0]          gnt_o
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] pick;
    logic       timeout;

    wb_rr_pick u_pick (
        .req_i  ({m1_cyc_i, m0_cyc_i}),
        .last_i (last_q),
        .pick_o (pick)
    );

    always_ff @(posedge clk_i or negedge ext_rst_i) begin
        if (!ext_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counts only stalled strobes; any termination or tenure change restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || s_ack_i || s_err_i || s_rty_i)
            cnt_d = '0;
        else if ((state_q != ST_IDLE) && s_stb_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge ext_rst_i) begin
        if (!ext_rst_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick[0])      state_d = ST_GNT0;
                else if (pick[1]) state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (timeout || (!m0_cyc_i && !m0_lock_i)) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (timeout || (!m1_cyc_i && !m1_lock_i)) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = {SEL_W{1'b0}};
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_lock_o = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        gnt_o    = 2'b00;
        case (state_q)
            ST_GNT0: begin
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_stb_i & ~timeout;
                s_lock_o = m0_lock_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout;
                m0_rty_o = s_rty_i;
                gnt_o    = 2'b01;
            end
            ST_GNT1: begin
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_stb_i & ~timeout;
                s_lock_o = m1_lock_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout;
                m1_rty_o = s_rty_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Directed self-checking bench for wb_uart_arbiter; the watchdog scenario
// runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_uart_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          ext_rst_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_lock_i, m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_lock_i, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_lock_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    gnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_uart_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .ext_rst_i(ext_rst_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_lock_i(m0_lock_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_lock_i(m1_lock_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_lock_o(s_lock_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt_o(gnt_o)
    );

    // Inputs change 1ns after a rising edge; checks happen 3ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_addr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_lock_i = 1'b0;
        m1_addr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_lock_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ext_rst_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h4; s_ack_i = 1'b1;
        step(); step();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt_o); end
        total++; if ({s_cyc_o, s_stb_o, s_we_o, s_lock_o} !== 4'b0) begin bad++; $display("FAIL rst_s_ctl got=%b exp=0000", {s_cyc_o, s_stb_o, s_we_o, s_lock_o}); end
        total++; if (s_addr_o !== 32'h0) begin bad++; $display("FAIL rst_s_addr got=%h exp=0", s_addr_o); end
        total++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin bad++; $display("FAIL rst_acks got=%b exp=00", {m0_ack_o, m1_ack_o}); end
        clear_inputs();
        step();
        ext_rst_i = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_sel_i = 4'hF;
        m0_addr_i = 32'h4; m0_dat_i = 32'h4000_0000;
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL wr_latency got=%b exp=00", gnt_o); end
        step();
        s_ack_i = 1'b1;
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt_o); end
        total++; if (s_addr_o !== 32'h4) begin bad++; $display("FAIL wr_addr got=%h exp=4", s_addr_o); end
        total++; if (s_dat_o !== 32'h4000_0000) begin bad++; $display("FAIL wr_dat got=%h exp=40000000", s_dat_o); end
        total++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b111_1111) begin bad++; $display("FAIL wr_ctl got=%b exp=1111111", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}); end
        total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL wr_ack got=%b exp=10", {m0_ack_o, m1_ack_o}); end
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        #3;
        total++; if ({gnt_o, s_cyc_o} !== 3'b010) begin bad++; $display("FAIL wr_drop got=%b exp=010", {gnt_o, s_cyc_o}); end
        step();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL wr_release got=%b exp=00", gnt_o); end
    endtask

    task automatic test_tie_from_reset();
        clear_inputs();
        ext_rst_i = 1'b0;
        step();
        ext_rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL tie_first got=%b exp=01", gnt_o); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL tie_gap got=%b exp=00", gnt_o); end
        step();
        #3;
        total++; if ({gnt_o, s_cyc_o} !== 3'b101) begin bad++; $display("FAIL tie_second got=%b exp=101", {gnt_o, s_cyc_o}); end
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL tie_gap2 got=%b exp=00", gnt_o); end
        step();
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL tie_third got=%b exp=01", gnt_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_read_m1();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h5; m1_sel_i = 4'hF;
        step();
        s_dat_i = 32'h20; s_ack_i = 1'b1;
        #3;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL rd_gnt got=%b exp=10", gnt_o); end
        total++; if ({s_addr_o, s_we_o} !== {32'h5, 1'b0}) begin bad++; $display("FAIL rd_addr got=%h/%b exp=5/0", s_addr_o, s_we_o); end
        total++; if (m1_dat_o !== 32'h20) begin bad++; $display("FAIL rd_m1_dat got=%h exp=20", m1_dat_o); end
        total++; if (m0_dat_o !== 32'h0) begin bad++; $display("FAIL rd_m0_dat got=%h exp=0", m0_dat_o); end
        // Ack in the same cycle cyc drops still belongs to m1.
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        total++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin bad++; $display("FAIL rd_rel_ack got=%b exp=01", {m0_ack_o, m1_ack_o}); end
        step();
        clear_inputs();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rd_release got=%b exp=00", gnt_o); end
    endtask

    task automatic test_lock();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_lock_i = 1'b1;
        m0_addr_i = 32'h7; m0_dat_i = 32'h11; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        s_ack_i = 1'b1;
        #3;
        total++; if ({gnt_o, s_lock_o, s_addr_o} !== {2'b01, 1'b1, 32'h7}) begin bad++; $display("FAIL lk_first got=%b/%b/%h exp=01/1/7", gnt_o, s_lock_o, s_addr_o); end
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            #3;
            total++; if ({gnt_o, s_cyc_o, m1_ack_o} !== 4'b0100) begin bad++; $display("FAIL lk_hold%0d got=%b exp=0100", i, {gnt_o, s_cyc_o, m1_ack_o}); end
        end
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h3; m0_dat_i = 32'h22; s_ack_i = 1'b1;
        #3;
        total++; if ({gnt_o, s_addr_o, m0_ack_o} !== {2'b01, 32'h3, 1'b1}) begin bad++; $display("FAIL lk_second got=%b/%h/%b exp=01/3/1", gnt_o, s_addr_o, m0_ack_o); end
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL lk_hold2 got=%b exp=01", gnt_o); end
        m0_lock_i = 1'b0;
        step();
        #3;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL lk_release got=%b exp=00", gnt_o); end
        step();
        #3;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL lk_m1 got=%b exp=10", gnt_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        exp_gnt = 2'b01;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            #3;
            total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt_o, exp_gnt); end
            s_ack_i = 1'b1;
            if (exp_gnt == 2'b01) m0_cyc_i = 1'b0; else m1_cyc_i = 1'b0;
            #1;
            total++; if ({m1_ack_o, m0_ack_o} !== exp_gnt) begin bad++; $display("FAIL rr_ack%0d got=%b exp=%b", i, {m1_ack_o, m0_ack_o}, exp_gnt); end
            step();
            s_ack_i = 1'b0; m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
            #3;
            total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rr_gap%0d got=%b exp=00", i, gnt_o); end
            exp_gnt = ~exp_gnt;
        end
        clear_inputs();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h5;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #3;
            total++; if ({gnt_o, m1_err_o, s_stb_o} !== 4'b1001) begin bad++; $display("FAIL to_wait%0d got=%b exp=1001", i, {gnt_o, m1_err_o, s_stb_o}); end
            step();
        end
        #3;
        total++; if ({gnt_o, m1_err_o, m0_err_o, s_cyc_o, s_stb_o} !== 6'b101000) begin bad++; $display("FAIL to_fire got=%b exp=101000", {gnt_o, m1_err_o, m0_err_o, s_cyc_o, s_stb_o}); end
        step();
        #3;
        total++; if ({gnt_o, m1_err_o} !== 3'b000) begin bad++; $display("FAIL to_idle got=%b exp=000", {gnt_o, m1_err_o}); end
        step();
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_next got=%b exp=01", gnt_o); end
        clear_inputs();
        step(); step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_tie_from_reset();
        test_read_m1();
        test_lock();
        test_fairness();
`ifdef WB_ARB_TIMEOUT_EN
        step();
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
